// File: rtl/avr_dmem_resp_if.sv
// avr_dmem_resp_if
//   Request/response signals between the AVR core (master) and the data-memory
//   responder (slave).
//
//   Handshake: the core raises data_write or data_read and holds it, together
//   with d_addr (and the write byte on the bus), until it sees ready. The
//   responder holds ready high until the core drops the request line; the
//   access is complete on the first cycle in which ready is high.
//
//   Signals
//     d_addr      core -> resp  16  byte address
//     data_write  core -> resp   1  write request (level)
//     data_read   core -> resp   1  read request (level)
//     ready       resp -> core   1  access complete, held until request drops
//     err         resp -> core   1  one-cycle error pulse
//     busy        resp -> core   1  responder not idle
//
//   The tri-state data byte is carried on a plain inout port of the responder,
//   so that bus resolution stays at a single module boundary.
interface avr_dmem_resp_if;
  logic [15:0] d_addr;
  logic        data_write;
  logic        data_read;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output d_addr, data_write, data_read,
    input  ready, err, busy
  );

  modport slave (
    input  d_addr, data_write, data_read,
    output ready, err, busy
  );
endinterface

// File: rtl/avr_dmem_resp.sv
// avr_dmem_resp
//   Data-memory responder at the far end of the AVR core's data bus. Decodes
//   the SRAM window [BASE, BASE+DEPTH-1] (top clipped to 16'hFFFF), inserts
//   WAIT wait states, then commits a write or fetches a read byte, and answers
//   with a level ready flag. Read data is driven on the shared bus only while
//   responding to a read.
//
//   Ports
//     CLK        in     1   system clock, rising edge
//     RST_N      in     1   asynchronous active-low reset
//     bus        slave      request/handshake signals (avr_dmem_resp_if)
//     data       inout  8   shared data bus
//     dbg_state  out    2   current FSM state (IDLE=0 WAIT=1 ACCESS=2 RESP=3)
//     dbg_drive  out    1   high while this block drives data
//
//   FSM: IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE
module avr_dmem_resp #(
  parameter logic [15:0] BASE    = 16'h0060,
  parameter int          DEPTH   = 1024,
  parameter int          WAIT    = 0,
  parameter logic [7:0]  RD_FILL = 8'hFF
) (
  input  logic            CLK,
  input  logic            RST_N,
  avr_dmem_resp_if.slave  bus,
  inout  wire  [7:0]      data,
  output logic [1:0]      dbg_state,
  output logic            dbg_drive
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Last mapped address, clipped so the window never wraps past 16'hFFFF.
  localparam int unsigned LAST_RAW  = 32'(BASE) + 32'(DEPTH) - 32'd1;
  localparam logic [15:0] LAST      = (LAST_RAW > 32'h0000_FFFF) ? 16'hFFFF : 16'(LAST_RAW);
  localparam logic [3:0]  WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic        op_wr_q;
  logic        hit_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [3:0]  cnt_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH];

  logic        req_any;
  logic        hit_d;
  logic        req_line;
  logic [AW-1:0] idx;
  logic        drive_en;

  assign req_any  = bus.data_write | bus.data_read;
  assign hit_d    = (bus.d_addr >= BASE) && (bus.d_addr <= LAST);
  // A conflicting request is latched as a write, so data_write is the line
  // that keeps it alive.
  assign req_line = op_wr_q ? bus.data_write : bus.data_read;
  assign idx      = AW'(addr_q - BASE);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        // Dropping the request here abandons the access before anything
        // is committed.
        if (!req_line)          state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (!req_line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter, read data and error pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q  <= 16'h0000;
      op_wr_q <= 1'b0;
      hit_q   <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            addr_q  <= bus.d_addr;
            op_wr_q <= bus.data_write;
            hit_q   <= hit_d;
            if (bus.data_write) wdata_q <= data;
            cnt_q   <= WAIT_INIT;
            err_q   <= bus.data_write & bus.data_read;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          rdata_q <= hit_q ? mem[idx] : RD_FILL;
          if (!hit_q) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // SRAM array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_ACCESS && op_wr_q && hit_q) mem[idx] <= wdata_q;
  end

  assign drive_en  = (state_q == S_RESP) && !op_wr_q;
  assign data      = drive_en ? rdata_q : 8'hzz;

  assign bus.ready = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.err   = err_q;

  assign dbg_state = state_q;
  assign dbg_drive = drive_en;

endmodule

// File: tb/tb_avr_dmem_resp.sv
module tb_avr_dmem_resp;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // ---------------- three instances: index 0 WAIT=0, 1 WAIT=3, 2 WAIT=2 ----
  logic [15:0] a_v  [3];
  logic [7:0]  dv_v [3];
  logic [2:0]  w_v, r_v, de_v;

  wire  [7:0]  d0, d1, d2;
  wire  [2:0]  rdy, erp, bsy, drv;
  wire  [1:0]  st0, st1, st2;

  avr_dmem_resp_if if0();
  avr_dmem_resp_if if1();
  avr_dmem_resp_if if2();

  assign if0.d_addr = a_v[0]; assign if0.data_write = w_v[0]; assign if0.data_read = r_v[0];
  assign if1.d_addr = a_v[1]; assign if1.data_write = w_v[1]; assign if1.data_read = r_v[1];
  assign if2.d_addr = a_v[2]; assign if2.data_write = w_v[2]; assign if2.data_read = r_v[2];

  assign rdy = {if2.ready, if1.ready, if0.ready};
  assign erp = {if2.err,   if1.err,   if0.err};
  assign bsy = {if2.busy,  if1.busy,  if0.busy};

  assign d0 = de_v[0] ? dv_v[0] : 8'hzz;
  assign d1 = de_v[1] ? dv_v[1] : 8'hzz;
  assign d2 = de_v[2] ? dv_v[2] : 8'hzz;

  avr_dmem_resp #(.WAIT(0)) u_w0 (.CLK(CLK), .RST_N(RST_N), .bus(if0), .data(d0), .dbg_state(st0), .dbg_drive(drv[0]));
  avr_dmem_resp #(.WAIT(3)) u_w3 (.CLK(CLK), .RST_N(RST_N), .bus(if1), .data(d1), .dbg_state(st1), .dbg_drive(drv[1]));
  avr_dmem_resp #(.WAIT(2)) u_w2 (.CLK(CLK), .RST_N(RST_N), .bus(if2), .data(d2), .dbg_state(st2), .dbg_drive(drv[2]));

  function automatic logic [7:0] bus_val(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Raises a request in the low phase, scrambles address/data once latched,
  // waits for ready (bounded), drops the request and watches two more cycles.
  task automatic access(input int k, input bit wr, input bit rd,
                        input logic [15:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd_out, output int lat,
                        output int errs, output int drv_cnt, output int busy_low);
    int cyc;
    bit done;
    @(negedge CLK);
    a_v[k] = addr; dv_v[k] = wd; w_v[k] = wr; r_v[k] = rd; de_v[k] = wr;
    lat = -1; errs = 0; drv_cnt = 0; busy_low = 0; rd_out = 8'h00; cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        a_v[k]  = addr ^ 16'h0001;
        dv_v[k] = ~wd;
      end
      if (erp[k]) errs++;
      if (wr && drv[k]) drv_cnt++;
      if (!bsy[k]) busy_low++;
      if (rdy[k]) begin
        lat = cyc;
        rd_out = bus_val(k);
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ready_timeout inst=%0d addr=%h: no ready within %0d cycles", k, addr, cyc);
    end
    w_v[k] = 1'b0; r_v[k] = 1'b0; de_v[k] = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (erp[k]) errs++;
      if (wr && drv[k]) drv_cnt++;
    end
    checks++;
    if (rdy[k] !== 1'b0 || bsy[k] !== 1'b0) begin
      errors++;
      $display("FAIL release inst=%0d: ready=%b busy=%b, required 0 0", k, rdy[k], bsy[k]);
    end
  endtask

  logic [7:0] rv;
  int lat, errs, dcnt, blow;

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({rdy, bsy, erp, drv} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b bsy=%b err=%b drv=%b, required all 0", rdy, bsy, erp, drv);
    end
    @(negedge CLK); RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    access(0, 1, 0, 16'h0080, 8'hE7, rv, lat, errs, dcnt, blow);
    @(negedge CLK);
    a_v[0] = 16'h0080; r_v[0] = 1'b1;
    for (int i = 0; i < 10 && !rdy[0]; i++) @(negedge CLK);
    checks++;
    if (rdy[0] !== 1'b1 || drv[0] !== 1'b1 || bus_val(0) !== 8'hE7) begin
      errors++;
      $display("FAIL resp_before_reset: ready=%b drive=%b data=%h, required 1 1 e7", rdy[0], drv[0], bus_val(0));
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || erp[0] !== 1'b0 || drv[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b busy=%b err=%b drive=%b, required 0 0 0 0", rdy[0], bsy[0], erp[0], drv[0]);
    end
    r_v[0] = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bsy[0] !== 1'b0 || st0 !== 2'd0 || drv[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b state=%0d drive=%b, required 0 0 0", bsy[0], st0, drv[0]);
    end
  endtask

  task automatic test_write_read();
    access(0, 1, 0, 16'h0100, 8'hA5, rv, lat, errs, dcnt, blow);
    checks++;
    if (lat !== 2 || errs !== 0) begin
      errors++;
      $display("FAIL wr_w0: latency=%0d err_pulses=%0d, required 2 0", lat, errs);
    end
    access(0, 0, 1, 16'h0100, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (lat !== 2 || errs !== 0 || rv !== 8'hA5) begin
      errors++;
      $display("FAIL rd_w0: latency=%0d err_pulses=%0d data=%h, required 2 0 a5", lat, errs, rv);
    end
  endtask

  task automatic test_wait_states();
    access(1, 1, 0, 16'h0060, 8'h3C, rv, lat, errs, dcnt, blow);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL wr_w3_latency: latency=%0d, required 5", lat);
    end
    access(1, 0, 1, 16'h0060, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (lat !== 5 || rv !== 8'h3C || blow !== 0) begin
      errors++;
      $display("FAIL rd_w3: latency=%0d data=%h busy_low_cycles=%0d, required 5 3c 0", lat, rv, blow);
    end
  endtask

  task automatic test_out_of_window();
    access(0, 1, 0, 16'h0060, 8'hC3, rv, lat, errs, dcnt, blow);
    access(0, 1, 0, 16'h0450, 8'h77, rv, lat, errs, dcnt, blow);
    access(0, 0, 1, 16'h0060, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (rv !== 8'hC3) begin
      errors++;
      $display("FAIL prior_readback: data=%h, required c3", rv);
    end
    access(0, 1, 0, 16'h0050, 8'h33, rv, lat, errs, dcnt, blow);
    checks++;
    if (errs !== 1 || lat !== 2) begin
      errors++;
      $display("FAIL miss_write: err_pulses=%0d latency=%0d, required 1 2", errs, lat);
    end
    access(0, 0, 1, 16'h0050, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (errs !== 1 || rv !== 8'hFF) begin
      errors++;
      $display("FAIL miss_read_low: err_pulses=%0d data=%h, required 1 ff", errs, rv);
    end
    access(0, 0, 1, 16'h0460, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (errs !== 1 || rv !== 8'hFF) begin
      errors++;
      $display("FAIL miss_read_high: err_pulses=%0d data=%h, required 1 ff", errs, rv);
    end
    access(0, 0, 1, 16'h0060, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (errs !== 0 || rv !== 8'hC3) begin
      errors++;
      $display("FAIL sram_unchanged_0060: err_pulses=%0d data=%h, required 0 c3", errs, rv);
    end
    access(0, 0, 1, 16'h0450, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (rv !== 8'h77) begin
      errors++;
      $display("FAIL sram_unchanged_0450: data=%h, required 77", rv);
    end
  endtask

  task automatic test_conflict_abort();
    int rdy_seen;
    bit busy_wait;
    access(0, 1, 1, 16'h0200, 8'h5A, rv, lat, errs, dcnt, blow);
    checks++;
    if (errs !== 1 || lat !== 2 || dcnt !== 0) begin
      errors++;
      $display("FAIL conflict: err_pulses=%0d latency=%0d drive_cycles=%0d, required 1 2 0", errs, lat, dcnt);
    end
    access(0, 0, 1, 16'h0200, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (rv !== 8'h5A) begin
      errors++;
      $display("FAIL conflict_readback: data=%h, required 5a", rv);
    end

    access(2, 1, 0, 16'h0201, 8'h44, rv, lat, errs, dcnt, blow);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wr_w2_latency: latency=%0d, required 4", lat);
    end
    @(negedge CLK);
    a_v[2] = 16'h0201; dv_v[2] = 8'h99; w_v[2] = 1'b1; de_v[2] = 1'b1;
    @(negedge CLK);
    busy_wait = bsy[2];
    w_v[2] = 1'b0; de_v[2] = 1'b0;
    rdy_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (rdy[2]) rdy_seen++;
    end
    checks++;
    if (busy_wait !== 1'b1 || rdy_seen !== 0 || bsy[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy_in_wait=%b ready_cycles=%0d busy_after=%b, required 1 0 0", busy_wait, rdy_seen, bsy[2]);
    end
    access(2, 0, 1, 16'h0201, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (rv !== 8'h44) begin
      errors++;
      $display("FAIL abort_readback: data=%h, required 44", rv);
    end
  endtask

  task automatic test_stack();
    access(0, 1, 0, 16'h045F, 8'h11, rv, lat, errs, dcnt, blow);
    checks++;
    if (dcnt !== 0 || errs !== 0) begin
      errors++;
      $display("FAIL push: drive_cycles=%0d err_pulses=%0d, required 0 0", dcnt, errs);
    end
    access(0, 0, 1, 16'h045F, 8'h00, rv, lat, errs, dcnt, blow);
    checks++;
    if (rv !== 8'h11 || lat !== 2) begin
      errors++;
      $display("FAIL pop: data=%h latency=%0d, required 11 2", rv, lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      a_v[k] = 16'h0000;
      dv_v[k] = 8'h00;
    end
    w_v = 3'b000; r_v = 3'b000; de_v = 3'b000;
    repeat (3) @(negedge CLK);
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_window();
    test_conflict_abort();
    test_stack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avr_dmem_resp.md
Name: avr_dmem_resp

Overview:
Data-memory responder on the far end of the AVR core's data bus (d_addr / data / data_write). It decodes the SRAM window, inserts programmable wait states, and commits writes or returns read data on the shared tri-state bus. A level handshake with a `ready` flag tells the core when to drop `stall`. It serves the core's PUSH/POP and future LD/ST paths.

Parameters:
- BASE, 16'h0060, first data-space address mapped to SRAM (0x00-0x5F are regs/IO, handled in the core).
- DEPTH, 1024, number of SRAM bytes. The window is BASE to BASE+DEPTH-1.
- WAIT, 0, extra wait cycles before completion (0-15).
- RD_FILL, 8'hFF, byte returned on a read that misses the window.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- d_addr  in  16  byte address from the core.
- data  inout  8  shared data bus. The core drives it on writes; this block drives it on read responses only.
- data_write  in  1  write request, level, held until `ready` is seen.
- data_read  in  1  read request, level, held until `ready` is seen.
- ready  out  1  access complete. Stays high until the request drops.
- err  out  1  one-cycle pulse on an out-of-window access or a read/write conflict.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FSM goes to IDLE; ready=0, err=0, busy=0.
  - data bus is released (Z); wait counter=0.
  - SRAM contents are not reset.
- FSM states:
  - IDLE: at a rising edge with data_write or data_read high:
    - latch d_addr into addr_q, the op, and for a write the bus byte into wdata_q;
    - the in-window check, (d_addr >= BASE) && (d_addr - BASE < DEPTH), is latched as hit_q;
    - go to WAIT if WAIT>0, else ACCESS.
  - WAIT: counter runs from WAIT-1 down to 0, then goes to ACCESS. Exactly WAIT cycles are spent here.
  - ACCESS: one cycle.
    - Write with hit_q: mem[addr_q-BASE] <= wdata_q.
    - Read with hit_q: rdata_q <= mem[addr_q-BASE].
    - Any miss: write is dropped, rdata_q <= RD_FILL, err pulses on the following cycle.
    - Next state is RESP.
  - RESP:
    - ready=1.
    - If op=read, drive data=rdata_q; otherwise data stays Z.
    - Stay while the latched request line is still high; return to IDLE on the edge after it drops.
    - ready falls and the bus releases in the same cycle the FSM enters IDLE.
- Latency:
  - Request first high in cycle N, latched at edge N; ready is high from cycle N+2+WAIT.
  - With WAIT=0, ready is high 2 cycles after the request.
- Conflict: data_write and data_read both high in IDLE.
  - Treated as a write (write wins).
  - err pulses for one cycle, concurrently with entry to WAIT/ACCESS.
- Changing d_addr or data after the request is latched has no effect.
- Abort: if the request line drops while in WAIT, the FSM returns to IDLE next edge. No write is committed and ready never rises.
- Back-to-back requests: a new request is accepted only from IDLE. The request must be low for at least one edge between accesses.
- Address arithmetic: unsigned 16-bit. BASE+DEPTH beyond 16'hFFFF is clipped to 16'hFFFF. The memory index is addr_q-BASE, truncated to clog2(DEPTH) bits.
- busy is high in WAIT, ACCESS and RESP.
- The bus is never driven in any state except RESP with op=read.

Test Plan:
1. Reset and bus release.
   - Stimulus: RST_N=0 mid-RESP of a read.
   - Required: ready, err, busy go to 0 immediately without waiting for CLK; data goes to Z.
   - After release with no request: remains in IDLE.
2. Write then read, WAIT=0.
   - Stimulus: write 8'hA5 to 16'h0100, hold until ready, drop; then read 16'h0100.
   - Required: ready at cycle N+2 for each access; data=8'hA5 while ready; err never pulses.
3. Wait states, WAIT=3.
   - Stimulus: read 16'h0060.
   - Required: ready first high at N+5; busy high from N+1 until the request drops.
4. Out of window.
   - Stimulus: write 8'h33 to 16'h0050, then read 16'h0050 and 16'h0460 (DEPTH=1024).
   - Required: err pulses once per access; reads return 8'hFF; SRAM unchanged, verified by a prior readback at 16'h0060.
5. Conflict and abort.
   - Stimulus: data_write=data_read=1 with 8'h5A at 16'h0200.
   - Required: err pulse; later read of 16'h0200 returns 8'h5A.
   - Stimulus (WAIT=2): drop a write to 16'h0201 after 1 cycle in WAIT.
   - Required: ready never rises; 16'h0201 keeps its old value.
6. Stack pattern.
   - Stimulus: PUSH-style write of 8'h11 to SP=16'h045F, then POP-style read of 16'h045F.
   - Required: returns 8'h11; the bus is never driven by this block during the write.
